// File: rtl/register_file_if.sv
// Bus between decode/writeback and the register file: two read ports and one write port.
interface register_file_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] RS1;
  logic [ADDR_WIDTH-1:0] RS2;
  logic [ADDR_WIDTH-1:0] RD;
  logic                  wr_en_RF;
  logic [DATA_WIDTH-1:0] Data_In_RF;
  logic [DATA_WIDTH-1:0] OP1;
  logic [DATA_WIDTH-1:0] OP2;

  modport master (
    output RS1, RS2, RD, wr_en_RF, Data_In_RF,
    input  OP1, OP2
  );

  modport slave (
    input  RS1, RS2, RD, wr_en_RF, Data_In_RF,
    output OP1, OP2
  );
endinterface

// File: rtl/register_file.sv
// 32 x 32-bit RV32 register file: two combinational read ports, one synchronous write port, x0 = 0.
// Optional macro RF_BYPASS_EN enables write-through forwarding of Data_In_RF to matching read ports.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave rf
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [Depth];
  logic                  wr_hit;

  // x0 is never written, so it keeps its reset value of zero.
  assign wr_hit = rf.wr_en_RF && (rf.RD != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[rf.RD] <= rf.Data_In_RF;
    end
  end

  always_comb begin
    rf.OP1 = '0;
    rf.OP2 = '0;
    if (!rst) begin
      if (rf.RS1 != '0) rf.OP1 = regs[rf.RS1];
      if (rf.RS2 != '0) rf.OP2 = regs[rf.RS2];
`ifdef RF_BYPASS_EN
      if (wr_hit && (rf.RS1 == rf.RD)) rf.OP1 = rf.Data_In_RF;
      if (wr_hit && (rf.RS2 == rf.RD)) rf.OP2 = rf.Data_In_RF;
`endif
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench for register_file; expectations are hand-computed constants.
module tb_register_file;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a write before the next rising edge, then drop the enable just after it.
  task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
    bus.RD         = rd;
    bus.Data_In_RF = data;
    bus.wr_en_RF   = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en_RF   = 1'b0;
  endtask

  task automatic read2(input logic [4:0] a, input logic [4:0] b);
    bus.RS1 = a;
    bus.RS2 = b;
    #1;
  endtask

  logic [31:0] same_cycle_exp;

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    rst            = 1'b1;
    bus.RS1        = '0;
    bus.RS2        = '0;
    bus.RD         = '0;
    bus.wr_en_RF   = 1'b0;
    bus.Data_In_RF = '0;

    read2(5'd1, 5'd31);
    check_eq("reset_op1", bus.OP1, 32'h0);
    check_eq("reset_op2", bus.OP2, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 32; i++) begin
      read2(5'(i), 5'(31 - i));
      check_eq("sweep_op1", bus.OP1, 32'h0);
      check_eq("sweep_op2", bus.OP2, 32'h0);
    end

    // Three writes on consecutive edges.
    write_reg(5'd1, 32'hAAAA_AAAA);
    write_reg(5'd2, 32'hBBBB_BBBB);
    write_reg(5'd3, 32'hCCCC_CCCC);
    read2(5'd1, 5'd2);
    check_eq("seq_x1", bus.OP1, 32'hAAAA_AAAA);
    check_eq("seq_x2", bus.OP2, 32'hBBBB_BBBB);
    read2(5'd2, 5'd3);
    check_eq("seq_x2b", bus.OP1, 32'hBBBB_BBBB);
    check_eq("seq_x3", bus.OP2, 32'hCCCC_CCCC);

    // Write disabled.
    bus.RD         = 5'd4;
    bus.Data_In_RF = 32'hDDDD_DDDD;
    bus.wr_en_RF   = 1'b0;
    @(posedge clk);
    read2(5'd4, 5'd1);
    check_eq("wr_dis_x4", bus.OP1, 32'h0);

    // x0 protection.
    write_reg(5'd0, 32'hEEEE_EEEE);
    read2(5'd0, 5'd3);
    check_eq("x0_op1", bus.OP1, 32'h0);
    check_eq("x0_keep_x3", bus.OP2, 32'hCCCC_CCCC);

    // Write then read.
    write_reg(5'd4, 32'hDDDD_DDDD);
    read2(5'd4, 5'd1);
    check_eq("wr_x4", bus.OP1, 32'hDDDD_DDDD);
    check_eq("wr_keep_x1", bus.OP2, 32'hAAAA_AAAA);

    // Same-cycle read of the register being written; x0 never forwards.
`ifdef RF_BYPASS_EN
    same_cycle_exp = 32'h1234_5678;
`else
    same_cycle_exp = 32'h0;
`endif
    @(negedge clk);
    bus.RS1        = 5'd5;
    bus.RS2        = 5'd1;
    bus.RD         = 5'd5;
    bus.Data_In_RF = 32'h1234_5678;
    bus.wr_en_RF   = 1'b1;
    #1;
    check_eq("same_pre_op1", bus.OP1, same_cycle_exp);
    check_eq("same_pre_op2", bus.OP2, 32'hAAAA_AAAA);
    @(posedge clk);
    #1;
    bus.wr_en_RF = 1'b0;
    check_eq("same_post_op1", bus.OP1, 32'h1234_5678);
    @(negedge clk);
    bus.RD         = 5'd0;
    bus.RS1        = 5'd0;
    bus.Data_In_RF = 32'hFFFF_FFFF;
    bus.wr_en_RF   = 1'b1;
    #1;
    check_eq("x0_no_fwd", bus.OP1, 32'h0);
    @(posedge clk);
    #1;
    bus.wr_en_RF = 1'b0;

    // Back-to-back writes to the same register: last one wins.
    write_reg(5'd6, 32'h1111_1111);
    write_reg(5'd6, 32'h2222_2222);
    read2(5'd6, 5'd5);
    check_eq("last_wins_x6", bus.OP1, 32'h2222_2222);
    check_eq("keep_x5", bus.OP2, 32'h1234_5678);

    // Asynchronous reset mid-cycle, with a write pending that must be discarded.
    @(negedge clk);
    bus.RS1 = 5'd1;
    bus.RS2 = 5'd4;
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_op1", bus.OP1, 32'h0);
    check_eq("async_rst_op2", bus.OP2, 32'h0);
    bus.RD         = 5'd7;
    bus.RS1        = 5'd7;
    bus.Data_In_RF = 32'h7777_7777;
    bus.wr_en_RF   = 1'b1;
    #1;
    check_eq("rst_no_fwd", bus.OP1, 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_blocks_wr", bus.OP1, 32'h0);

    // First edge after deassertion commits the write.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.wr_en_RF = 1'b0;
    read2(5'd7, 5'd6);
    check_eq("post_rst_wr_x7", bus.OP1, 32'h7777_7777);
    check_eq("post_rst_x6_clr", bus.OP2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
